// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor computing a - b - bin over
//                WIDTH clock cycles, LSB first, through one full-subtractor
//                cell with a registered borrow.
//  Ports       : clk        - clock, all state updates on rising edge
//                rst        - asynchronous active-high reset
//                start      - operation request, sampled only while ready=1
//                a, b       - minuend / subtrahend, captured on accepted start
//                bin        - initial borrow-in, captured on accepted start
//                ready      - high only while idle
//                done       - one-cycle pulse, result valid
//                diff       - registered difference, held until next done
//                borrow_out - registered final borrow, held until next done
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // Counter value while the WIDTH-th (final) bit is being processed.
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sb_q, pd_q;
    logic               br_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;

    logic               w_x, w_y, w_d, w_br_next;
    logic [WIDTH-1:0]   w_pd_next;
    logic               w_accept, w_last;

    // Full-subtractor cell on the current LSB pair.
    assign w_x       = sa_q[0];
    assign w_y       = sb_q[0];
    assign w_d       = w_x ^ w_y ^ br_q;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & br_q);
    assign w_pd_next = {w_d, pd_q[WIDTH-1:1]};

    assign w_accept  = (state_q == c_IDLE) && start;
    assign w_last    = (state_q == c_SHIFT) && (cnt_q == c_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  state_d = start ? c_SHIFT : c_IDLE;
            c_SHIFT: state_d = (cnt_q == c_LAST) ? c_DONE : c_SHIFT;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;  // unused encoding recovers to idle
        endcase
    end

    // Output decode
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_q)
            c_IDLE:  ready = 1'b1;
            c_DONE:  done  = 1'b1;
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    // Datapath: operand shifters, borrow, partial result and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q  <= '0;
            sb_q  <= '0;
            pd_q  <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else if (w_accept) begin
            sa_q  <= a;
            sb_q  <= b;
            pd_q  <= '0;
            br_q  <= bin;
            cnt_q <= '0;
        end else if (state_q == c_SHIFT) begin
            sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
            sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
            pd_q  <= w_pd_next;
            br_q  <= w_br_next;
            cnt_q <= cnt_q + c_CNT_W'(1);
        end
    end

    // Result registers update only on the final shift edge, so the outputs
    // never expose a partially assembled difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (w_last) begin
            diff_q   <= w_pd_next;
            borrow_q <= w_br_next;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed and randomized self-checking bench for
//                serial_subtractor (WIDTH = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic             ready, done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .ready      (ready),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and return just after the accepting edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until done is observed; 0 means the bound expired.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    // Expected values derived from plain wide arithmetic.
    function automatic logic [7:0] exp_diff(input logic [7:0] ea, input logic [7:0] eb, input logic ebin);
        logic [15:0] t;
        t = {8'd0, ea} - {8'd0, eb} - {15'd0, ebin};
        return t[7:0];
    endfunction

    function automatic logic exp_borrow(input logic [7:0] ea, input logic [7:0] eb, input logic ebin);
        return ({1'b0, ea} < ({1'b0, eb} + {8'd0, ebin}));
    endfunction

    // Run one full operation and check result, latency and pulse width.
    task automatic run_check(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
        int n;
        start_op(ta, tb, tbin);
        wait_done(n);
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_diff(ta, tb, tbin)));
        chk({tag, "_borrow"}, 32'(borrow_out), 32'(exp_borrow(ta, tb, tbin)));
        tick();
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int n;
        int dones;
        int done_cyc[3];
        logic [7:0] ha[3];
        logic [7:0] hb[3];
        logic [7:0] ra, rb;
        logic rbin;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);

        // Basic vector with explicit latency and ready check
        start_op(8'h35, 8'h12, 1'b0);
        chk("shift_ready_low", 32'(ready), 32'd0);
        wait_done(n);
        chk("v1_latency", 32'(n), 32'd8);
        chk("v1_diff", 32'(diff), 32'h23);
        chk("v1_borrow", 32'(borrow_out), 32'd0);
        tick();
        chk("v1_done_width", 32'(done), 32'd0);

        // Hand-computed boundary vectors
        start_op(8'h00, 8'h01, 1'b0);
        wait_done(n);
        chk("v2_diff", 32'(diff), 32'hFF);
        chk("v2_borrow", 32'(borrow_out), 32'd1);
        tick();

        start_op(8'h80, 8'h7F, 1'b1);
        wait_done(n);
        chk("v3_diff", 32'(diff), 32'h00);
        chk("v3_borrow", 32'(borrow_out), 32'd0);
        tick();

        start_op(8'h00, 8'hFF, 1'b1);
        wait_done(n);
        chk("v4_diff", 32'(diff), 32'h00);
        chk("v4_borrow", 32'(borrow_out), 32'd1);
        tick();

        // start during SHIFT is ignored
        start_op(8'h10, 8'h01, 1'b0);
        tick(); tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                dones++;
                chk("ign_diff", 32'(diff), 32'h0F);
                chk("ign_borrow", 32'(borrow_out), 32'd0);
            end
        end
        chk("ign_done_count", 32'(dones), 32'd1);

        // Reset mid-operation
        start_op(8'h35, 8'h12, 1'b0);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_borrow", 32'(borrow_out), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        chk("mid_rst_no_done", 32'(dones), 32'd0);
        chk("mid_rst_diff_hold", 32'(diff), 32'd0);
        run_check("post_rst", 8'h05, 8'h07, 1'b0);

        // start held high: three back-to-back operations
        ha[0] = 8'h35; hb[0] = 8'h12;
        ha[1] = 8'h01; hb[1] = 8'h02;
        ha[2] = 8'hC8; hb[2] = 8'h64;
        a = ha[0]; b = hb[0]; bin = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(n);
            done_cyc[k] = cyc;
            chk("held_done_seen", 32'(n != 0), 32'd1);
            chk("held_diff", 32'(diff), 32'(exp_diff(ha[k], hb[k], 1'b0)));
            chk("held_borrow", 32'(borrow_out), 32'(exp_borrow(ha[k], hb[k], 1'b0)));
            if (k < 2) begin
                a = ha[k+1];
                b = hb[k+1];
            end
        end
        start = 1'b0;
        chk("held_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd10);
        chk("held_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd10);
        tick(); tick(); tick();

        // Randomized sweep
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            start_op(ra, rb, rbin);
            wait_done(n);
            chk("rand_diff", 32'(diff), 32'(exp_diff(ra, rb, rbin)));
            chk("rand_borrow", 32'(borrow_out), 32'(exp_borrow(ra, rb, rbin)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
